// File: rtl/ika9958_rcc_if.sv
// RCC output bundle: phase levels, phase strobes, pin images and reset/genlock status.
// The master drives every field; downstream VDP stages take the slave view.
interface ika9958_rcc_if;
    logic phia;
    logic phil;
    logic phia_pcen;
    logic phia_ncen;
    logic phil_pcen;
    logic phil_ncen;
    logic dhclk;
    logic dlclk;
    logic irst;
    logic hrst_n;
    logic hrst_fall;

    modport master (
        output phia, phil, phia_pcen, phia_ncen, phil_pcen, phil_ncen,
               dhclk, dlclk, irst, hrst_n, hrst_fall
    );

    modport slave (
        input  phia, phil, phia_pcen, phia_ncen, phil_pcen, phil_ncen,
               dhclk, dlclk, irst, hrst_n, hrst_fall
    );
endinterface

// File: rtl/ika9958_rcc.sv
// Reset/clock control: phiA/phiL phase grid as strobes, stretched internal reset, HRST sync.
// Latency: strobes combinational from the phase count; pins reach outputs after SYNC_STAGES cycles.
// No backpressure: free-running, advances only on i_CEN master ticks.
module ika9958_rcc #(
    parameter int RESET_HOLD  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          i_EMUCLK,
    input  logic          i_RST,
    input  logic          i_CEN,
    input  logic          i_EXTRST_n,
    input  logic          i_HRST_n,
    ika9958_rcc_if.master rcc
);

    localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD);

    logic [1:0]             cnt_q,       cnt_d;
    logic [SYNC_STAGES-1:0] ext_sync_q,  ext_sync_d;
    logic [SYNC_STAGES-1:0] hrst_sync_q, hrst_sync_d;
    logic                   hrst_prev_q, hrst_prev_d;
    logic [7:0]             hold_q,      hold_d;

    logic live;
    logic ext_synced;
    logic hrst_last;
    logic phia_pcen, phia_ncen, phil_pcen, phil_ncen;

    assign live       = i_CEN & ~i_RST;
    assign ext_synced = ext_sync_q[SYNC_STAGES-1];
    assign hrst_last  = hrst_sync_q[SYNC_STAGES-1];

    // Strobes announce the level change that the next enabled tick will make.
    assign phia_pcen = live &  cnt_q[0];
    assign phia_ncen = live & ~cnt_q[0];
    assign phil_pcen = live & (cnt_q == 2'd3);
    assign phil_ncen = live & (cnt_q == 2'd1);

    always_comb begin
        cnt_d       = cnt_q;
        ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0],  i_EXTRST_n};
        hrst_sync_d = {hrst_sync_q[SYNC_STAGES-2:0], i_HRST_n};
        hrst_prev_d = hrst_last;
        hold_d      = hold_q;

        if (i_CEN) begin
            cnt_d = cnt_q + 2'd1;
        end

        // A re-asserted external reset restarts the full stretch, even mid-countdown.
        if (!ext_synced) begin
            hold_d = HOLD_INIT;
        end else if (phil_ncen && (hold_q != 8'd0)) begin
            hold_d = hold_q - 8'd1;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            cnt_q       <= 2'd0;
            ext_sync_q  <= '0;
            hrst_sync_q <= '1;
            hrst_prev_q <= 1'b1;
            hold_q      <= HOLD_INIT;
        end else begin
            cnt_q       <= cnt_d;
            ext_sync_q  <= ext_sync_d;
            hrst_sync_q <= hrst_sync_d;
            hrst_prev_q <= hrst_prev_d;
            hold_q      <= hold_d;
        end
    end

    assign rcc.phia      = ~cnt_q[0];
    assign rcc.phil      = ~cnt_q[1];
    assign rcc.phia_pcen = phia_pcen;
    assign rcc.phia_ncen = phia_ncen;
    assign rcc.phil_pcen = phil_pcen;
    assign rcc.phil_ncen = phil_ncen;
    assign rcc.dhclk     = ~cnt_q[0];
    assign rcc.dlclk     = ~cnt_q[1];
    assign rcc.irst      = (hold_q != 8'd0);
    assign rcc.hrst_n    = hrst_last;
    assign rcc.hrst_fall = ~hrst_last & hrst_prev_q & ~i_RST;

endmodule

// File: tb/tb_ika9958_rcc.sv
// Directed bench for ika9958_rcc: per-cycle scoreboard against a behavioural model plus pinned checks.
module tb_ika9958_rcc;

    localparam int RH = 16;

    logic clk = 1'b0;
    logic i_RST, i_CEN, i_EXTRST_n, i_HRST_n;

    ika9958_rcc_if rcc_bus ();

    ika9958_rcc #(.RESET_HOLD(RH), .SYNC_STAGES(2)) dut (
        .i_EMUCLK   (clk),
        .i_RST      (i_RST),
        .i_CEN      (i_CEN),
        .i_EXTRST_n (i_EXTRST_n),
        .i_HRST_n   (i_HRST_n),
        .rcc        (rcc_bus.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int tcyc = 0;

    // Bit order: phia phil phia_p phia_n phil_p phil_n dh dl irst hrst_n hrst_fall
    logic [10:0] sb[$];
    logic [10:0] log_v [0:255];

    logic [1:0] mcnt, mext, mhr;
    logic       mhp;
    logic [7:0] mhold;

    function automatic logic [10:0] model_out(input logic rst, input logic cen);
        logic live;
        live = cen & ~rst;
        return {~mcnt[0], ~mcnt[1], live & mcnt[0], live & ~mcnt[0],
                live & (mcnt == 2'd3), live & (mcnt == 2'd1),
                ~mcnt[0], ~mcnt[1], (mhold != 8'd0), mhr[1], ~mhr[1] & mhp & ~rst};
    endfunction

    task automatic model_reset();
        mcnt = 2'd0; mext = 2'b00; mhr = 2'b11; mhp = 1'b1; mhold = 8'(RH);
    endtask

    task automatic model_step(input logic rst, input logic cen, input logic ext, input logic hr);
        if (rst) begin
            model_reset();
        end else begin
            if (!mext[1]) mhold = 8'(RH);
            else if (cen && mcnt == 2'd1 && mhold != 8'd0) mhold = mhold - 8'd1;
            mhp  = mhr[1];
            mext = {mext[0], ext};
            mhr  = {mhr[0], hr};
            if (cen) mcnt = mcnt + 2'd1;
        end
    endtask

    function automatic logic [10:0] observe();
        return {rcc_bus.phia, rcc_bus.phil, rcc_bus.phia_pcen, rcc_bus.phia_ncen,
                rcc_bus.phil_pcen, rcc_bus.phil_ncen, rcc_bus.dhclk, rcc_bus.dlclk,
                rcc_bus.irst, rcc_bus.hrst_n, rcc_bus.hrst_fall};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input logic rst, input logic cen, input logic ext, input logic hr);
        logic [10:0] exp_v, obs_v;
        @(negedge clk);
        i_RST = rst; i_CEN = cen; i_EXTRST_n = ext; i_HRST_n = hr;
        sb.push_back(model_out(rst, cen));
        #1;
        obs_v = observe();
        exp_v = sb.pop_front();
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL cyc%0d outputs obs=%b exp=%b", tcyc, obs_v, exp_v);
        end
        log_v[tcyc] = obs_v;
        tcyc++;
        model_step(rst, cen, ext, hr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_RST = 1'b1; i_CEN = 1'b1; i_EXTRST_n = 1'b0; i_HRST_n = 1'b1;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk); #1;
        chk("reset_state", int'(observe()), int'(11'b11000011110));
        tcyc = 0;
    endtask

    initial begin
        int n;
        i_RST = 1'b1; i_CEN = 1'b0; i_EXTRST_n = 1'b0; i_HRST_n = 1'b1;

        // Continuous enable, release at cycle 10: stretch ends after sync + 16 phiL falls.
        do_reset();
        for (int c = 0; c < 80; c++) cyc(1'b0, 1'b1, (c >= 10), 1'b1);
        chk("phia_c0..3", int'({log_v[0][10], log_v[1][10], log_v[2][10], log_v[3][10]}), 4'b1010);
        chk("phil_c0..3", int'({log_v[0][9], log_v[1][9], log_v[2][9], log_v[3][9]}), 4'b1100);
        chk("philn_1_5_9_13", int'({log_v[1][5], log_v[5][5], log_v[9][5], log_v[13][5]}), 4'b1111);
        chk("philn_c3", int'(log_v[3][5]), 0);
        chk("irst_c73", int'(log_v[73][2]), 1);
        chk("irst_c74", int'(log_v[74][2]), 0);
        n = 0;
        for (int c = 0; c < 74; c++) n += int'(log_v[c][2]);
        chk("irst_no_glitch", n, 74);

        // External reset re-pulsed for 3 cycles while hold=5: full reload.
        do_reset();
        for (int c = 0; c < 130; c++) cyc(1'b0, 1'b1, !(c < 10 || (c >= 55 && c <= 57)), 1'b1);
        n = 0;
        for (int c = 0; c < 122; c++) n += int'(log_v[c][2]);
        chk("irst_held_repulse", n, 122);
        chk("irst_c122", int'(log_v[122][2]), 0);

        // Alternating enable: phase only moves on enabled ticks.
        do_reset();
        for (int c = 0; c < 16; c++) cyc(1'b0, (c % 2 == 0), 1'b1, 1'b1);
        n = 0;
        for (int c = 1; c < 16; c += 2) n += int'(log_v[c][8]) + int'(log_v[c][7]) + int'(log_v[c][6]) + int'(log_v[c][5]);
        chk("strobes_disabled", n, 0);
        n = 0;
        for (int c = 0; c < 16; c++) n += int'(log_v[c][5]);
        chk("philn_count_8ticks", n, 2);
        n = 0;
        for (int c = 0; c < 16; c++) n += int'(log_v[c][8]);
        chk("phiap_count_8ticks", n, 4);

        // HRST_n falls at cycle 4 and stays low.
        do_reset();
        for (int c = 0; c < 16; c++) cyc(1'b0, 1'b1, 1'b1, (c < 4));
        chk("hrst_n_c5", int'(log_v[5][1]), 1);
        chk("hrst_n_c6", int'(log_v[6][1]), 0);
        chk("hrst_fall_c6", int'(log_v[6][0]), 1);
        n = 0;
        for (int c = 0; c < 16; c++) n += int'(log_v[c][0]);
        chk("hrst_fall_count", n, 1);

        // One-cycle i_RST at cnt=2.
        do_reset();
        for (int c = 0; c < 10; c++) cyc((c == 2), 1'b1, 1'b1, 1'b1);
        chk("midrst_strobes", int'(log_v[2][8:5]), 0);
        chk("midrst_levels_after", int'(log_v[3][10:9]), 3);
        chk("midrst_irst_after", int'(log_v[3][2]), 1);
        chk("midrst_hrst_after", int'(log_v[3][1]), 1);
        chk("midrst_philn_resume", int'(log_v[4][5]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ika9958_rcc.md
Name: ika9958_rcc

Overview:
Reset and clock control stage. It sits directly upstream of the screen-timing block and every other VDP stage. It divides the 21.48 MHz master clock into the phiA (÷2) and phiL (÷4) phase grid, expressed as clock-enable strobes on the single emulator clock. It also synchronizes and stretches the external VDP reset and synchronizes the HRST genlock pin. Its outputs drive the RCC interface fields phiA, phiA_NCEN, phiL_NCEN and related fields.

Parameters:
RESET_HOLD, 16, number of phiL negative-edge ticks the internal reset is held after the external reset is released (1..255).
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (≥2).

Ports:
i_EMUCLK  input  1  emulator clock; all logic uses the rising edge.
i_RST  input  1  reset; synchronous, active-high.
i_CEN  input  1  master-clock enable; one assertion = one 21.48 MHz master tick.
i_EXTRST_n  input  1  external VDP reset pin, async, active-low.
i_HRST_n  input  1  external horizontal reset pin, async, active-low.
o_PHIA  output  1  phiA level (master ÷2).
o_PHIL  output  1  phiL level (master ÷4).
o_PHIA_PCEN  output  1  strobe: phiA rises on the next master tick.
o_PHIA_NCEN  output  1  strobe: phiA falls on the next master tick.
o_PHIL_PCEN  output  1  strobe: phiL rises on the next master tick.
o_PHIL_NCEN  output  1  strobe: phiL falls on the next master tick.
o_DHCLK  output  1  DHCLK pin image; equals o_PHIA.
o_DLCLK  output  1  DLCLK pin image; equals o_PHIL.
o_IRST  output  1  stretched internal reset, active-high.
o_HRST_n  output  1  synchronized HRST_n.
o_HRST_FALL  output  1  one-cycle pulse on a synchronized HRST_n falling edge.

Behaviour:
- Phase counter cnt[1:0]:
  - Reset value 0.
  - When i_CEN=1: cnt <= cnt+1, wrapping 3→0.
  - When i_CEN=0: cnt holds.
- Level outputs:
  - o_PHIA = ~cnt[0].
  - o_PHIL = ~cnt[1].
  - Both read 1 in reset.
- Strobes are combinational decodes of cnt, ANDed with i_CEN and ~i_RST:
  - PHIA_PCEN when cnt[0]=1.
  - PHIA_NCEN when cnt[0]=0.
  - PHIL_PCEN when cnt=3.
  - PHIL_NCEN when cnt=1.
  - Every strobe is 0 in reset and whenever i_CEN=0.
- Strobe rates: each PHIA strobe is high on exactly 1 of 2 enabled ticks; each PHIL strobe is high on exactly 1 of 4 enabled ticks.
- Synchronizers:
  - Both pins use SYNC_STAGES flops clocked every i_EMUCLK, independent of i_CEN.
  - Reset value for the EXTRST chain: 0 (reset asserted).
  - Reset value for the HRST chain: 1.
- Reset stretcher:
  - hold[7:0] resets to RESET_HOLD.
  - While synced EXTRST_n=0: hold <= RESET_HOLD.
  - Otherwise, when o_PHIL_NCEN=1 and hold≠0: hold <= hold-1.
  - o_IRST = (hold≠0). It reads 1 in reset.
  - External reset re-asserted mid-countdown: hold reloads on the next cycle; o_IRST stays 1.
- HRST:
  - o_HRST_n = last synchronizer stage; reset value 1.
  - o_HRST_FALL = 1 for one cycle when the last stage is 0 and the previous stage value was 1.
  - o_HRST_FALL is not gated by i_CEN; it is 0 in reset.
- i_RST mid-operation: on the next edge, cnt=0, hold=RESET_HOLD and synchronizers are preset. There is no partial-phase output.
- Latencies:
  - Pin to synchronized output: SYNC_STAGES cycles.
  - EXTRST_n release to o_IRST fall: SYNC_STAGES cycles plus RESET_HOLD PHIL_NCEN ticks.

Test Plan:
1. i_CEN=1 continuous after reset, 16 cycles -> cnt 0,1,2,3,… ; o_PHIA toggles every cycle starting at 1; o_PHIL has period 4 (1,1,0,0); PHIL_NCEN high at cycles 1,5,9,13.
2. i_CEN pattern 1,0,1,0 -> phase advances only on enabled cycles; every strobe is 0 on disabled cycles; the period measured in enabled ticks is unchanged.
3. RESET_HOLD=16, i_CEN=1, EXTRST_n released at cycle 10 -> o_IRST falls exactly after 2 sync cycles plus 16 PHIL_NCEN ticks (≈64 cycles); no glitch before that.
4. EXTRST_n pulsed low for 3 cycles while hold=5 -> hold reloads to 16; o_IRST stays 1 throughout and falls 16 ticks after the second release.
5. HRST_n driven 1→0 -> o_HRST_n falls after 2 cycles; o_HRST_FALL is high for exactly 1 cycle; holding the pin low produces no further pulses.
6. i_RST asserted for 1 cycle at cnt=2 -> next cycle cnt=0, all strobes 0, o_IRST=1, o_HRST_n=1; normal sequencing resumes from cnt=0.
